// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency ROM read port between two requesters.
// Optional requester-0 burst lock is built when ROM_ARB_LOCK_EN is defined.
module rom_port_arbiter #(
  parameter int AW     = 11,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req0,
  input  logic [AW-1:0] i_addr0,
  output logic          o_gnt0,
  output logic          o_rvalid0,
  input  logic          i_req1,
  input  logic [AW-1:0] i_addr1,
  output logic          o_gnt1,
  output logic          o_rvalid1,
  output logic [DW-1:0] o_rdata,
  input  logic          i_lock,
  output logic          o_rom_en,
  output logic [AW-1:0] o_rom_addr,
  input  logic [DW-1:0] i_rom_data
);

  logic              last_q, last_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] id_q, id_d;
  logic              gnt0, gnt1;
  logic              lock_act;

`ifdef ROM_ARB_LOCK_EN
  logic locked_q, locked_d;

  // lock only holds while requester 0 keeps both lock and request up
  assign lock_act = locked_q & i_lock & i_req0;

  always_comb begin
    locked_d = locked_q;
    if (!i_lock || !i_req0) begin
      locked_d = 1'b0;
    end else if (gnt0) begin
      locked_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= locked_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = i_lock;
  assign lock_act    = 1'b0;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (lock_act) begin
        gnt0 = 1'b1;
      end else begin
        unique case (1'b1)
          (i_req0 & i_req1): begin
            gnt0 = last_q;
            gnt1 = ~last_q;
          end
          (i_req0 & ~i_req1): gnt0 = 1'b1;
          (~i_req0 & i_req1): gnt1 = 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign o_gnt0   = gnt0;
  assign o_gnt1   = gnt1;
  assign o_rom_en = gnt0 | gnt1;

  always_comb begin
    o_rom_addr = '0;
    if (gnt0) begin
      o_rom_addr = i_addr0;
    end else if (gnt1) begin
      o_rom_addr = i_addr1;
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end
  end

  // tag pipeline mirrors the ROM latency so data is steered by id
  always_comb begin
    vld_d    = vld_q;
    id_d     = id_q;
    vld_d[0] = o_rom_en;
    id_d[0]  = gnt1;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
      vld_q  <= '0;
      id_q   <= '0;
    end else begin
      last_q <= last_d;
      vld_q  <= vld_d;
      id_q   <= id_d;
    end
  end

  assign o_rvalid0 = vld_q[RD_LAT-1] & ~id_q[RD_LAT-1];
  assign o_rvalid1 = vld_q[RD_LAT-1] & id_q[RD_LAT-1];
  assign o_rdata   = i_rom_data;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a transaction-level reference model.
// Lock expectations follow ROM_ARB_LOCK_EN when the bench is built with it.
module tb_rom_port_arbiter;

  localparam int AW  = 11;
  localparam int DW  = 16;
  localparam int LAT = 2;

  typedef struct {
    int id;
    int addr;
    int cyc;
    int data;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req0, i_req1, i_lock;
  logic [AW-1:0] i_addr0, i_addr1;
  logic          o_gnt0, o_gnt1, o_rvalid0, o_rvalid1;
  logic [DW-1:0] o_rdata;
  logic          o_rom_en;
  logic [AW-1:0] o_rom_addr;
  logic [DW-1:0] i_rom_data;

  logic [AW-1:0] rom_pipe [LAT];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  ev_t pend [$];
  ev_t gq   [$];
  ev_t rq   [$];
  int  m_last   = 1;
  bit  m_locked = 1'b0;

  rom_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req0     (i_req0),
    .i_addr0    (i_addr0),
    .o_gnt0     (o_gnt0),
    .o_rvalid0  (o_rvalid0),
    .i_req1     (i_req1),
    .i_addr1    (i_addr1),
    .o_gnt1     (o_gnt1),
    .o_rvalid1  (o_rvalid1),
    .o_rdata    (o_rdata),
    .i_lock     (i_lock),
    .o_rom_en   (o_rom_en),
    .o_rom_addr (o_rom_addr),
    .i_rom_data (i_rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
    return {{(DW-AW){1'b0}}, a} ^ 16'hBEEF;
  endfunction

  // ROM with LAT cycles from enable/address to data
  always @(posedge clk) begin
    rom_pipe[0] <= o_rom_addr;
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign i_rom_data = romf(rom_pipe[LAT-1]);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int pack(input ev_t q[$]);
    int s = 0;
    foreach (q[i]) s |= (q[i].id << i);
    return s;
  endfunction

  // per-cycle reference: grant choice, return schedule, and logging
  always @(negedge clk) begin
    int            g;
    int            ev;
    logic [AW-1:0] ga;
    logic [DW-1:0] ed;
    if (chk_en) begin
      g = -1;
      if (!rst) begin
        if (m_locked && i_lock && i_req0) g = 0;
        else if (i_req0 && i_req1) g = (m_last == 1) ? 0 : 1;
        else if (i_req0) g = 0;
        else if (i_req1) g = 1;
      end
      ga = (g == 0) ? i_addr0 : (g == 1) ? i_addr1 : '0;
      chk("gnt0", o_gnt0, g == 0);
      chk("gnt1", o_gnt1, g == 1);
      chk("rom_en", o_rom_en, g >= 0);
      chk("rom_addr", o_rom_addr, ga);
      ev = -1;
      ed = '0;
      if (pend.size() > 0 && pend[0].cyc == cyc) begin
        ev = pend[0].id;
        ed = romf(pend[0].addr[AW-1:0]);
        void'(pend.pop_front());
      end
      chk("rvalid0", o_rvalid0, ev == 0);
      chk("rvalid1", o_rvalid1, ev == 1);
      if (ev >= 0) chk("rdata", o_rdata, ed);
      if (o_gnt0 || o_gnt1)
        gq.push_back('{int'(o_gnt1), int'(o_rom_addr), cyc, 0});
      if (o_rvalid0 || o_rvalid1)
        rq.push_back('{int'(o_rvalid1), 0, cyc, int'(o_rdata)});
      if (rst) begin
        pend.delete();
        m_last   = 1;
        m_locked = 1'b0;
      end else begin
        if (g >= 0) begin
          pend.push_back('{g, int'(ga), cyc + LAT, 0});
          m_last = g;
        end
`ifdef ROM_ARB_LOCK_EN
        m_locked = i_lock && i_req0 && (m_locked || g == 0);
`endif
      end
      cyc++;
    end
  end

  task automatic step(input logic r, input logic q0, input int a0,
                      input logic q1, input int a1, input logic lk);
    rst     = r;
    i_req0  = q0;
    i_addr0 = a0[AW-1:0];
    i_req1  = q1;
    i_addr1 = a1[AW-1:0];
    i_lock  = lk;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    gq.delete();
    rq.delete();
  endtask

  initial begin
    rst     = 1'b1;
    i_req0  = 1'b0;
    i_req1  = 1'b0;
    i_addr0 = '0;
    i_addr1 = '0;
    i_lock  = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    do_reset();

    // single request
    step(0, 1, 'h123, 0, 0, 0);
    idle(4);
    chk("t1_gcnt", gq.size(), 1);
    chk("t1_rcnt", rq.size(), 1);
    if (gq.size() == 1 && rq.size() == 1) begin
      chk("t1_gid", gq[0].id, 0);
      chk("t1_gaddr", gq[0].addr, 'h123);
      chk("t1_rid", rq[0].id, 0);
      chk("t1_rdata", rq[0].data, 'hBFCC);
      chk("t1_lat", rq[0].cyc - gq[0].cyc, 2);
    end

    // contention after reset
    do_reset();
    for (int i = 0; i < 6; i++) step(0, 1, 'h010, 1, 'h020, 0);
    idle(4);
    chk("t2_gcnt", gq.size(), 6);
    chk("t2_gseq", pack(gq), 'b101010);
    chk("t2_rcnt", rq.size(), 6);
    chk("t2_rseq", pack(rq), 'b101010);
    if (rq.size() >= 2) begin
      chk("t2_rdata0", rq[0].data, 'hBEFF);
      chk("t2_rdata1", rq[1].data, 'hBECF);
    end

    // idle cycles keep the pointer
    do_reset();
    step(0, 0, 0, 1, 'h020, 0);
    idle(3);
    step(0, 1, 'h010, 1, 'h020, 0);
    idle(4);
    chk("t3_gcnt", gq.size(), 2);
    chk("t3_gseq", pack(gq), 'b01);

    // burst lock
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 'h010 + i, 1, 'h020, 1);
    step(0, 1, 'h014, 1, 'h020, 0);
    idle(4);
    chk("t4_gcnt", gq.size(), 5);
`ifdef ROM_ARB_LOCK_EN
    chk("t4_gseq", pack(gq), 'b10000);
`else
    chk("t4_gseq", pack(gq), 'b01010);
`endif

    // reset mid-flight with requests held during reset
    do_reset();
    step(0, 1, 'h055, 0, 0, 0);
    step(1, 1, 'h055, 1, 'h020, 0);
    step(0, 1, 'h010, 1, 'h020, 0);
    idle(4);
    chk("t5_gcnt", gq.size(), 2);
    chk("t5_gseq", pack(gq), 'b00);
    if (gq.size() == 2) chk("t5_gap", gq[1].cyc - gq[0].cyc, 2);
    chk("t5_rcnt", rq.size(), 1);
    if (rq.size() == 1) begin
      chk("t5_rid", rq[0].id, 0);
      chk("t5_rdata", rq[0].data, 'hBEFF);
    end

    chk("model_drained", pend.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
